// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer slice.
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    WRITE,
    DONE,
    ERR_DZ,
    ERR_TO
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Bus bundle between control unit, mult/div units and the sequencer.
interface muldiv_sequencer_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic              req;
  logic              op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              mult_start;
  logic              div_start;
  logic              mult_ready;
  logic              div_ready;
  logic [DATA_W-1:0] mult_hi;
  logic [DATA_W-1:0] mult_lo;
  logic [DATA_W-1:0] div_hi;
  logic [DATA_W-1:0] div_lo;
  logic [DATA_W-1:0] hi_in;
  logic [DATA_W-1:0] lo_in;
  logic              hi_wr;
  logic              lo_wr;
  logic              busy;
  logic              done;
  logic              div_zero;
  logic              timeout;

  modport slave (
    input  req, op, a, b, mult_ready, div_ready,
           mult_hi, mult_lo, div_hi, div_lo,
    output op_a, op_b, mult_start, div_start,
           hi_in, lo_in, hi_wr, lo_wr, busy, done, div_zero, timeout
  );

  modport master (
    output req, op, a, b, mult_ready, div_ready,
           mult_hi, mult_lo, div_hi, div_lo,
    input  op_a, op_b, mult_start, div_start,
           hi_in, lo_in, hi_wr, lo_wr, busy, done, div_zero, timeout
  );

endinterface

// File: rtl/muldiv_sequencer_cycle_timer.sv
// Clear/increment WAIT-cycle counter with terminal count at TIMEOUT_CYCLES-1.
module cycle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic terminal
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // Counter saturates at terminal so it can never wrap.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && !terminal) begin
      count <= count + CNT_W'(1);
    end
  end

  assign terminal = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences one mult/div request: latch operands, start unit, wait for
// ready (with timeout), write HI/LO, and report done or an exception.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic                clk,
  input logic                reset,
  muldiv_sequencer_if.slave  bus
);

  state_t            state;
  state_t            state_nx;
  logic              op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              sel_ready;
  logic              terminal;
  logic              tmr_clear;
  logic              tmr_inc;
  logic              mult_start;
  logic              div_start;
  logic              wr;
  logic              done;
  logic              div_zero;
  logic              timeout;

  assign sel_ready = (op_q == OP_DIV) ? bus.div_ready : bus.mult_ready;

  cycle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .inc     (tmr_inc),
    .terminal(terminal)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Operand latch on accepted request; result capture on selected ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= OP_MULT;
      a_q  <= '0;
      b_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (state == IDLE && bus.req) begin
        op_q <= bus.op;
        a_q  <= bus.a;
        b_q  <= bus.b;
      end
      if (state == WAIT && sel_ready) begin
        hi_q <= (op_q == OP_DIV) ? bus.div_hi : bus.mult_hi;
        lo_q <= (op_q == OP_DIV) ? bus.div_lo : bus.mult_lo;
      end
    end
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    state_nx   = state;
    tmr_clear  = 1'b0;
    tmr_inc    = 1'b0;
    mult_start = 1'b0;
    div_start  = 1'b0;
    wr         = 1'b0;
    done       = 1'b0;
    div_zero   = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req) begin
          state_nx = (bus.op == OP_DIV && bus.b == '0) ? ERR_DZ : START;
        end
      end
      START: begin
        tmr_clear  = 1'b1;
        mult_start = (op_q == OP_MULT);
        div_start  = (op_q == OP_DIV);
        state_nx   = WAIT;
      end
      WAIT: begin
        if (sel_ready) begin
          state_nx = WRITE;
        end else if (terminal) begin
          state_nx = ERR_TO;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      WRITE: begin
        wr       = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      ERR_DZ: begin
        div_zero = 1'b1;
        state_nx = IDLE;
      end
      ERR_TO: begin
        timeout  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.op_a       = a_q;
  assign bus.op_b       = b_q;
  assign bus.hi_in      = hi_q;
  assign bus.lo_in      = lo_q;
  assign bus.mult_start = mult_start;
  assign bus.div_start  = div_start;
  assign bus.hi_wr      = wr;
  assign bus.lo_wr      = wr;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done;
  assign bus.div_zero   = div_zero;
  assign bus.timeout    = timeout;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer with behavioural mult/div units.
module tb_muldiv_sequencer;

  localparam int DW = 32;
  localparam int T  = 8;

  typedef struct {
    int          kind;       // 0 = write, 1 = div_zero, 2 = timeout
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          start_cyc;
    int          ev_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  int          next_delay = 0;
  int          m_at = -1;
  int          d_at = -1;
  logic [31:0] m_hi = '0, m_lo = '0, d_hi = '0, d_lo = '0;
  logic [31:0] last_hi = '0, last_lo = '0;
  int          pend_done = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_sequencer_if #(.DATA_W(DW)) bus ();

  muldiv_sequencer #(
    .DATA_W(DW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural multiplier/divider: results from the latched operands,
  // ready pulsed once, next_delay cycles into WAIT.
  always @(negedge clk) begin
    if (!reset && bus.mult_start) begin
      {m_hi, m_lo} = {32'b0, bus.op_a} * {32'b0, bus.op_b};
      if (next_delay < T) m_at = cyc + 1 + next_delay;
    end
    if (!reset && bus.div_start && bus.op_b != 0) begin
      d_lo = bus.op_a / bus.op_b;
      d_hi = bus.op_a % bus.op_b;
      if (next_delay < T) d_at = cyc + 1 + next_delay;
    end
  end

  always @(posedge clk) begin
    #1;
    bus.mult_ready = (cyc == m_at);
    bus.div_ready  = (cyc == d_at);
    bus.mult_hi    = m_hi;
    bus.mult_lo    = m_lo;
    bus.div_hi     = d_hi;
    bus.div_lo     = d_lo;
  end

  // Monitor: pops the scoreboard on every start/result/exception event.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      pend_done = -1;
      last_hi   = '0;
      last_lo   = '0;
    end else begin
      logic exp_busy;
      exp_t e;
      exp_busy = (q.size() > 0 && cyc >= q[0].start_cyc) || (cyc == pend_done);
      chk("busy", bus.busy, exp_busy);
      if (bus.mult_start || bus.div_start) begin
        if (q.size() == 0) begin
          chk("start_unexpected", 1, 0);
        end else begin
          e = q[0];
          chk("start_allowed", e.kind != 1, 1);
          chk("start_cycle", cyc, e.start_cyc);
          chk("start_sel", {bus.mult_start, bus.div_start}, e.op ? 2'b01 : 2'b10);
          chk("op_a", bus.op_a, e.a);
          chk("op_b", bus.op_b, e.b);
        end
      end
      if (bus.hi_wr || bus.lo_wr || bus.div_zero || bus.timeout) begin
        if (q.size() == 0) begin
          chk("event_unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          chk("event_kind", bus.hi_wr ? 0 : (bus.div_zero ? 1 : 2), e.kind);
          chk("event_cycle", cyc, e.ev_cyc);
          chk("done_in_event", bus.done, 0);
          if (e.kind == 0) begin
            chk("wr_pair", {bus.hi_wr, bus.lo_wr}, 2'b11);
            chk("hi_in", bus.hi_in, e.hi);
            chk("lo_in", bus.lo_in, e.lo);
            last_hi   = e.hi;
            last_lo   = e.lo;
            pend_done = cyc + 1;
          end else begin
            chk("no_wr", {bus.hi_wr, bus.lo_wr}, 2'b00);
            chk("hi_hold", bus.hi_in, last_hi);
            chk("lo_hold", bus.lo_in, last_lo);
          end
        end
      end
      if (bus.done || cyc == pend_done) begin
        chk("done_pulse", {bus.done, cyc == pend_done}, 2'b11);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise req for one cycle and push the reference outcome.
  task automatic issue_start(input logic op, input logic [31:0] a, input logic [31:0] b,
                             input int d);
    exp_t e;
    logic [63:0] p;
    e.op = op; e.a = a; e.b = b; e.hi = '0; e.lo = '0;
    e.start_cyc = cyc + 1;
    if (op && b == 0) begin
      e.kind = 1; e.ev_cyc = cyc + 1;
    end else if (d < T) begin
      e.kind = 0; e.ev_cyc = cyc + 3 + d;
      if (op) begin
        e.lo = a / b; e.hi = a % b;
      end else begin
        p = {32'b0, a} * {32'b0, b};
        e.hi = p[63:32]; e.lo = p[31:0];
      end
    end else begin
      e.kind = 2; e.ev_cyc = cyc + 2 + T;
    end
    q.push_back(e);
    next_delay = d;
    bus.req = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    tick();
    bus.req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 40) begin
      tick();
      n++;
    end
    chk("idle_reached", bus.busy, 0);
  endtask

  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b, input int d);
    issue_start(op, a, b, d);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        op;
    logic [31:0] a, b;
    reset = 1'b1;
    bus.req = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    bus.mult_ready = 1'b0; bus.div_ready = 1'b0;
    bus.mult_hi = '0; bus.mult_lo = '0; bus.div_hi = '0; bus.div_lo = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_outputs", {bus.busy, bus.done, bus.div_zero, bus.timeout, bus.hi_wr,
                        bus.lo_wr, bus.mult_start, bus.div_start}, 8'h00);
    chk("rst_data", {bus.op_a | bus.op_b, bus.hi_in | bus.lo_in}, 64'h0);
    tick();

    // Directed cases.
    issue(1'b0, 32'd7, 32'd6, 2);
    issue(1'b1, 32'd100, 32'd7, 0);
    issue(1'b1, 32'd5, 32'd0, 0);
    issue(1'b0, 32'd3, 32'd4, 20);
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    issue(1'b1, 32'hFFFF_FFFF, 32'd1, T - 1);

    // Stray div_ready and a busy-time DIV-by-zero request during MULT WAIT.
    issue_start(1'b0, 32'd1234, 32'd5678, 6);
    tick();
    d_at = cyc + 2;
    bus.req = 1'b1; bus.op = 1'b1; bus.a = 32'd9; bus.b = 32'd0;
    tick();
    bus.req = 1'b0;
    wait_idle();

    // Reset during WAIT; the late mult_ready must be ignored.
    issue_start(1'b0, 32'd11, 32'd13, 2);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_outputs", {bus.busy, bus.done, bus.hi_wr, bus.lo_wr, bus.mult_start,
                           bus.div_start, bus.div_zero, bus.timeout}, 8'h00);
    chk("midrst_data", {bus.op_a | bus.op_b, bus.hi_in | bus.lo_in}, 64'h0);
    repeat (3) tick();
    issue(1'b0, 32'd21, 32'd2, 1);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      op = 1'($urandom % 2);
      a  = $urandom;
      case ($urandom % 4)
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      issue(op, a, b, int'($urandom_range(0, 10)));
      if ($urandom % 2 == 1) tick();
    end

    repeat (4) tick();
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller that sits between the control unit and the shared multiplier/divider pair.
- Accepts one mult/div request at a time and latches its operands. Pulses the start line of the selected unit, then waits for that unit's ready.
- Captures the unit's hi/lo result and drives the single HI/LO register write port.
- Detects divide-by-zero before starting the divider, and aborts on a ready timeout.

Parameters:
- DATA_W, 32, operand and result width.
- TIMEOUT_CYCLES, 64, maximum number of WAIT cycles before abort; must be at least 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  request strobe from control unit; sampled only in IDLE.
- op  input  1  0 = MULT, 1 = DIV; sampled with req.
- a  input  DATA_W  operand A (rs value); sampled with req.
- b  input  DATA_W  operand B (rt value); sampled with req.
- op_a  output  DATA_W  latched A to both units.
- op_b  output  DATA_W  latched B to both units.
- mult_start  output  1  one-cycle start pulse to multiplier.
- div_start  output  1  one-cycle start pulse to divider.
- mult_ready  input  1  multiplier done.
- div_ready  input  1  divider done.
- mult_hi, mult_lo  input  DATA_W each  multiplier results.
- div_hi, div_lo  input  DATA_W each  divider remainder/quotient.
- hi_in, lo_in  output  DATA_W each  data to HI/LO registers.
- hi_wr, lo_wr  output  1 each  HI/LO write enables.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- div_zero  output  1  one-cycle exception pulse.
- timeout  output  1  one-cycle abort pulse.

Behaviour:
- All control outputs are Moore decodes of state; they assert in the cycle the state is entered.
- Reset (synchronous, overrides everything, including mid-operation):
  - state=IDLE.
  - op_a, op_b, hi_in, lo_in, counter, latched op = 0.
  - All 1-bit outputs = 0.
  - Any ready arriving after reset is ignored.
- IDLE: if req=1, latch op, a→op_a, b→op_b.
  - If op=DIV and b==0 → ERR_DZ.
  - Otherwise → START.
- START: assert mult_start (op=MULT) or div_start (op=DIV), never both; counter:=0; → WAIT. Ready inputs seen in START are ignored as stale.
- WAIT: only the selected unit's ready is honoured; the other unit's ready is ignored.
  - If selected ready=1: capture hi/lo into hi_in/lo_in → WRITE.
  - Else if counter==TIMEOUT_CYCLES-1 → ERR_TO.
  - Else counter++.
  - At most TIMEOUT_CYCLES WAIT cycles.
- WRITE: hi_wr=lo_wr=1 for exactly one cycle → DONE.
- DONE: done=1 → IDLE.
- ERR_DZ: div_zero=1; no start pulse, no hi_wr/lo_wr → IDLE.
- ERR_TO: timeout=1; no hi_wr/lo_wr; HI/LO data untouched → IDLE.
- Output holding:
  - op_a/op_b hold from latch until the next accepted req.
  - hi_in/lo_in hold the last captured values until the next capture.
- Latency: req accepted at cycle 0, start at cycle 1, WAIT from cycle 2. With ready at cycle k: write at k+1, done at k+2. Minimum is 4 cycles from req to done.
- req while busy (including the DONE/ERR cycles) is dropped; no queuing.
- Counter width is clog2(TIMEOUT_CYCLES+1); it never wraps.

Decomposition:
- Shared package muldiv_pkg holds:
  - state encoding: IDLE, START, WAIT, WRITE, DONE, ERR_DZ, ERR_TO;
  - op codes OP_MULT=1'b0, OP_DIV=1'b1.
- One natural sub-module: cycle_timer. It holds the clear/increment counter with a terminal-count output at TIMEOUT_CYCLES-1. The FSM stays in muldiv_sequencer.

Test Plan:
1. MULT 7×6, multiplier model returns hi=0, lo=42 with ready 3 cycles after start.
   - mult_start at cycle 1 only; div_start=0.
   - hi_wr=lo_wr=1 at cycle 5 with hi_in=0, lo_in=42; done at cycle 6.
   - busy high for cycles 1–6.
2. DIV 100/7, divider model returns lo=14, hi=2, ready at first WAIT cycle.
   - div_start at cycle 1, write at cycle 3 with hi_in=2, lo_in=14, done at cycle 4.
3. DIV a=5, b=0.
   - div_zero=1 at cycle 1; no start pulse, no hi_wr/lo_wr, done=0.
   - IDLE at cycle 2; hi_in/lo_in keep their previous values.
4. TIMEOUT_CYCLES=8, MULT, ready never asserted.
   - timeout=1 at cycle 10; no writes; back to IDLE at cycle 11.
   - A new req at cycle 11 is accepted.
5. MULT in flight: div_ready pulsed and a second req (DIV, b=0) issued during WAIT.
   - Both are ignored; no div_zero pulse; completes with the multiplier's result only.
6. reset asserted during WAIT, then mult_ready=1 the next cycle.
   - All outputs 0 and state IDLE after the reset edge; no hi_wr/done generated.
   - A subsequent req works normally.
